// File: rtl/perceptron_feeder.sv
// ============================================================================
// Module   : perceptron_feeder
// Purpose  : Buffers one input vector and a bias, starts the perceptron,
//            streams the vector to it and captures its result.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module perceptron_feeder #(
    parameter int N_INPUTS    = 784,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic              ld_we,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [DATA_W-1:0] bias_in,
    input  logic              run,
    output logic              start,
    output logic [DATA_W-1:0] bias,
    output logic [DATA_W-1:0] x_tdata,
    output logic              x_tvalid,
    input  logic              x_tready,
    input  logic              done,
    input  logic [DATA_W-1:0] a_tdata,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic              timeout
);

    localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_STREAM    = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_d;
    logic                x_tvalid_q, x_tvalid_d;
    logic [DATA_W-1:0]   bias_q, bias_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;

    logic [DATA_W-1:0]   mem_q [N_INPUTS];
    logic                mem_we;

    // Loads are only accepted while idle so the vector cannot change mid-stream.
    assign mem_we = (state_q == S_IDLE) && ld_we && (ld_addr <= LAST_IDX);

    always_ff @(posedge s_axi_aclk) begin
        if (mem_we) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        start_d        = 1'b0;
        x_tvalid_d     = x_tvalid_q;
        bias_d         = bias_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_d      = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    bias_d    = bias_in;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    start_d   = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                x_tvalid_d = 1'b1;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (x_tvalid_q && x_tready) begin
                    if (idx_q == LAST_IDX) begin
                        x_tvalid_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = S_WAIT_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                // A done arriving on the final counted cycle still wins over the abort.
                if (done) begin
                    result_d       = a_tdata;
                    result_valid_d = 1'b1;
                    idx_d          = '0;
                    state_d        = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    idx_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                x_tvalid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            start_q        <= 1'b0;
            x_tvalid_q     <= 1'b0;
            bias_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            start_q        <= start_d;
            x_tvalid_q     <= x_tvalid_d;
            bias_q         <= bias_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            timeout_q      <= timeout_d;
        end
    end

    assign start        = start_q;
    assign bias         = bias_q;
    assign x_tdata      = mem_q[idx_q];
    assign x_tvalid     = x_tvalid_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign timeout      = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_perceptron_feeder.sv
// ============================================================================
// Module   : tb_perceptron_feeder
// Purpose  : Scoreboard bench for perceptron_feeder acting as host and perceptron.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_perceptron_feeder;

    localparam int N  = 784;
    localparam int DW = 32;
    localparam int IW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_we = 1'b0;
    logic [IW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [DW-1:0] bias_in = '0;
    logic          run = 1'b0;
    logic          start;
    logic [DW-1:0] bias;
    logic [DW-1:0] x_tdata;
    logic          x_tvalid;
    logic          x_tready = 1'b0;
    logic          done = 1'b0;
    logic [DW-1:0] a_tdata = '0;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          timeout;

    perceptron_feeder #(
        .N_INPUTS    (N),
        .DATA_W      (DW),
        .IDX_W       (IW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .bias_in      (bias_in),
        .run          (run),
        .start        (start),
        .bias         (bias),
        .x_tdata      (x_tdata),
        .x_tvalid     (x_tvalid),
        .x_tready     (x_tready),
        .done         (done),
        .a_tdata      (a_tdata),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mdl [N];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] res_q [$];
    logic [DW-1:0] last_res = '0;

    int start_cnt = 0;
    int busy_cnt  = 0;
    int rv_cnt    = 0;
    int pop_cnt   = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Perceptron-side observer: outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (start) start_cnt++;
        if (busy) busy_cnt++;
        if (result_valid) begin
            rv_cnt++;
            if (res_q.size() == 0) check_val("rv_unexpected", 1, 0);
            else                   check_val("result", result, res_q.pop_front());
        end
        if (prev_stall && !rst) begin
            check_val("stall_valid", x_tvalid, 1);
            check_val("stall_data", x_tdata, prev_data);
        end
        if (x_tvalid && x_tready && !rst) begin
            if (exp_q.size() == 0) check_val("extra_word", 1, 0);
            else                   check_val("word", x_tdata, exp_q.pop_front());
            pop_cnt++;
        end
        prev_stall = x_tvalid && !x_tready && !rst;
        prev_data  = x_tdata;
    end

    task automatic do_inference(input bit rand_ready, input int dly, input bit give_done,
                                input logic [DW-1:0] aval, input logic [DW-1:0] bval,
                                input bit poke, input int rst_at);
        int cyc;
        int n;
        start_cnt = 0;
        busy_cnt  = 0;
        rv_cnt    = 0;
        pop_cnt   = 0;
        for (int i = 0; i < N; i++) exp_q.push_back(mdl[i]);
        bias_in = bval;
        run     = 1'b1;
        tick();
        run     = 1'b0;
        bias_in = ~bval;
        check_val("start_pulse", start, 1);
        check_val("busy_start", busy, 1);
        check_val("timeout_cleared", timeout, 0);
        check_val("bias_latched", bias, bval);

        cyc = 0;
        while (exp_q.size() != 0) begin
            if (cyc >= 20000) begin
                check_val("stream_budget", 0, 1);
                exp_q.delete();
                break;
            end
            if (rst_at > 0 && pop_cnt == rst_at) begin
                rst = 1'b1;
                #1;
                check_val("rst_start", start, 0);
                check_val("rst_tvalid", x_tvalid, 0);
                check_val("rst_tdata", x_tdata, mdl[0]);
                check_val("rst_bias", bias, 0);
                check_val("rst_result", result, 0);
                check_val("rst_rv", result_valid, 0);
                check_val("rst_busy", busy, 0);
                check_val("rst_timeout", timeout, 0);
                x_tready = 1'b0;
                tick();
                rst = 1'b0;
                exp_q.delete();
                last_res = '0;
                return;
            end
            x_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && cyc == 20) begin
                ld_we = 1'b1; ld_addr = IW'(5); ld_data = 32'hDEAD; run = 1'b1;
            end else begin
                ld_we = 1'b0; run = 1'b0;
            end
            tick();
            cyc++;
        end
        x_tready = 1'b0;
        ld_we    = 1'b0;
        run      = 1'b0;
        check_val("wait_tvalid", x_tvalid, 0);

        if (give_done) begin
            repeat (dly) tick();
            done    = 1'b1;
            a_tdata = aval;
            res_q.push_back(aval);
            last_res = aval;
            tick();
            done = 1'b0;
            n = 0;
            while (rv_cnt == 0 && n < 50) begin
                tick();
                n++;
            end
            tick();
            check_val("rv_pulses", rv_cnt, 1);
            check_val("start_count", start_cnt, 1);
            check_val("busy_end", busy, 0);
            check_val("bias_held", bias, bval);
            check_val("result_hold", result, aval);
        end else begin
            repeat (TO - 1) tick();
            check_val("timeout_early", timeout, 0);
            tick();
            check_val("timeout_set", timeout, 1);
            check_val("busy_timeout", busy, 0);
            check_val("result_kept", result, last_res);
            check_val("rv_none", rv_cnt, 0);
        end
    endtask

    initial begin
        repeat (3) tick();
        check_val("reset_start", start, 0);
        check_val("reset_tvalid", x_tvalid, 0);
        check_val("reset_bias", bias, 0);
        check_val("reset_result", result, 0);
        check_val("reset_rv", result_valid, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_timeout", timeout, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) begin
            ld_we = 1'b1; ld_addr = IW'(i); ld_data = DW'(i + 1);
            mdl[i] = DW'(i + 1);
            tick();
        end
        // Out-of-range index must not alias onto any real word.
        ld_addr = IW'(N); ld_data = 32'h0BAD_0BAD;
        tick();
        ld_we = 1'b0;
        tick();

        do_inference(1'b0, 1, 1'b1, 32'h1234, 32'h0800_0000, 1'b0, 0);
        check_val("busy_cycles", busy_cnt, 787);

        do_inference(1'b1, 3, 1'b1, 32'h5678, 32'h0000_0011, 1'b0, 0);
        do_inference(1'b0, 0, 1'b0, 32'h0, 32'h0000_0022, 1'b0, 0);
        do_inference(1'b1, 2, 1'b1, 32'h9ABC, 32'h0000_0033, 1'b1, 0);
        repeat (4) tick();
        check_val("run_not_queued", busy, 0);
        check_val("no_extra_start", start_cnt, 1);

        do_inference(1'b0, 0, 1'b1, 32'h4444, 32'h0000_0044, 1'b0, 0);
        do_inference(1'b0, 0, 1'b1, 32'h0, 32'h0000_0055, 1'b0, 300);
        tick();
        do_inference(1'b1, 1, 1'b1, 32'h7777, 32'h0000_0066, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/perceptron_feeder.md
# perceptron_feeder

Transmit-side companion to the perceptron: holds one input vector (784 pixel words by default) and a bias, fires the perceptron's start, streams the vector over the x_tdata/x_tvalid/x_tready handshake, then waits for done and captures a_tdata. Sits between the host-side load path and one perceptron instance, one feeder per perceptron.

## Interface
- N_INPUTS, 784, words per vector; the perceptron consumes exactly this many.
- DATA_W, 32, word width, Q-format passed through untouched.
- IDX_W, 10, index width, ceil(log2(N_INPUTS)).
- TIMEOUT_CYC, 4096, max cycles in WAIT_DONE before abort.

Ports:
- s_axi_aclk  in  1  single clock, rising edge.
- s_axi_areset  in  1  asynchronous, active-high reset.
- ld_we  in  1  write strobe into vector buffer; honoured in IDLE only.
- ld_addr  in  IDX_W  buffer word index; values >= N_INPUTS ignored.
- ld_data  in  DATA_W  buffer write data.
- bias_in  in  DATA_W  bias, sampled when run is accepted.
- run  in  1  request one inference; level, accepted in IDLE only.
- start  out  1  to perceptron start; one-cycle high pulse.
- bias  out  DATA_W  to perceptron bias; held from run acceptance until next acceptance.
- x_tdata  out  DATA_W  stream data, buf[idx].
- x_tvalid  out  1  stream valid.
- x_tready  in  1  stream ready from perceptron.
- done  in  1  perceptron done level.
- a_tdata  in  DATA_W  perceptron result.
- result  out  DATA_W  captured a_tdata.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky; set on WAIT_DONE expiry, cleared by next accepted run.

## Operation
- Buffer: N_INPUTS x DATA_W register array, synchronous write, asynchronous read; contents not cleared by reset.
- FSM states IDLE, START, STREAM, WAIT_DONE.
- IDLE: ld_we writes buffer. run=1 -> latch bias_in into bias, clear timeout, idx<=0, go START.
- START: start=1 for this one cycle; go STREAM.
- STREAM: x_tvalid=1, x_tdata=buf[idx]. On x_tvalid&x_tready: if idx==N_INPUTS-1 go WAIT_DONE, else idx<=idx+1. No handshake -> x_tdata and x_tvalid held stable.
- WAIT_DONE: x_tvalid=0; timeout counter increments each cycle. done=1 -> result<=a_tdata, result_valid=1 for one cycle, go IDLE. Counter reaches TIMEOUT_CYC-1 without done -> timeout<=1, go IDLE, result unchanged.
- ld_we outside IDLE: dropped, buffer unchanged. run outside IDLE: ignored, not queued.
- run held high: new inference starts on the cycle after return to IDLE.
- Reset mid-operation: FSM to IDLE immediately; streaming abandons, perceptron recovers on its next start edge.

## Timing
- Reset values: start 0, x_tvalid 0, x_tdata buf[0], bias 0, result 0, result_valid 0, busy 0, timeout 0, idx 0, counter 0.
- run sampled at edge T -> start high in cycle T+1 -> x_tvalid high from T+2.
- With x_tready constantly high, N_INPUTS handshakes take exactly N_INPUTS cycles; first transfer is T+2 at the earliest.
- Perceptron raises x_tready one cycle after seeing start; feeder does not depend on it.
- done sampled only in WAIT_DONE; a stale done from a prior run is cleared by the perceptron on start, before WAIT_DONE is reached.
- result and result_valid registered; result_valid asserted the cycle after done seen.
- busy deasserts the same cycle result_valid asserts.

## Test plan
- Load buf[i]=i+1, bias_in=0x0800_0000, pulse run, x_tready constant 1, done after last word with a_tdata=0x1234 -> start pulses once, 784 words 1..784 in order, result=0x1234, one result_valid pulse, busy for 787 cycles.
- Same vector, x_tready toggles pseudo-randomly -> identical word sequence, x_tdata/x_tvalid stable during every stall, no word duplicated or skipped.
- Never assert done, TIMEOUT_CYC=16 -> timeout=1 exactly 16 cycles after WAIT_DONE entry, result unchanged, busy=0; next run clears timeout.
- ld_we with ld_addr=5, ld_data=0xDEAD during STREAM, and second run mid-stream -> buf[5] unchanged on rerun, only one start pulse per inference.
- Assert s_axi_areset at word 300 -> all outputs at reset values within the same cycle asynchronously; run after release streams from word 0.
- ld_addr=784 write -> ignored; buf[0..783] unchanged.
